// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU for the nRISC datapath: single-cycle logic/arith ops plus iterative MUL/DIV.
// Optional Carry/Overflow outputs when ULA_FLAGS_EN is defined.
module ula_multiciclo #(
  parameter int unsigned LARGURA   = 8,
  parameter int unsigned LARG_CONT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Inicio,
  input  logic [LARGURA-1:0] Fonte1,
  input  logic [LARGURA-1:0] Fonte2,
  input  logic [2:0]         ULAOp,
  output logic               Ocupado,
  output logic               Pronto,
  output logic [LARGURA-1:0] Resultado,
  output logic [LARGURA-1:0] ResultadoAlto,
  output logic               Zero,
`ifdef ULA_FLAGS_EN
  output logic               Carry,
  output logic               Overflow,
`endif
  output logic               ErroDiv
);

  typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_SLT = 3'b010, OP_AND = 3'b011,
    OP_OR  = 3'b100, OP_SLL = 3'b101, OP_MUL = 3'b110, OP_DIV = 3'b111
  } op_t;

  localparam logic [LARG_CONT-1:0] CONT_INI = LARG_CONT'(LARGURA);
  localparam logic [LARG_CONT-1:0] CONT_UM  = LARG_CONT'(1);

  estado_t              estado_q;
  op_t                  op_q;
  logic [LARGURA-1:0]   b_q;
  logic [LARGURA:0]     hi_q, hi_d;
  logic [LARGURA-1:0]   lo_q, lo_d;
  logic [LARG_CONT-1:0] cont_q;
  logic [LARGURA-1:0]   resultado_q, alto_q;
  logic                 zero_q, erro_q;

  op_t                  op_in;
  logic [LARGURA-1:0]   res_simples;
  logic [LARGURA:0]     dif;
  int unsigned          desl;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge
  always_comb begin
    op_in       = op_t'(ULAOp);
    dif         = {1'b0, Fonte1} - {1'b0, Fonte2};
    desl        = 32'(Fonte2[LARG_CONT-1:0]);
    res_simples = '0;
    case (op_in)
      OP_ADD:  res_simples = Fonte1 + Fonte2;
      OP_SUB:  res_simples = dif[LARGURA-1:0];
      OP_SLT:  res_simples = LARGURA'(dif[LARGURA]);
      OP_AND:  res_simples = Fonte1 & Fonte2;
      OP_OR:   res_simples = Fonte1 | Fonte2;
      OP_SLL:  res_simples = (desl >= LARGURA) ? '0 : (Fonte1 << desl);
      default: res_simples = '0;
    endcase
  end

  logic [LARGURA:0] hi_soma, desl_rem, tentativa;

  // One iteration: shift-add multiply on {hi,lo} shifting right, restoring divide shifting left
  always_comb begin
    hi_soma   = lo_q[0] ? (hi_q + {1'b0, b_q}) : hi_q;
    desl_rem  = {hi_q[LARGURA-1:0], lo_q[LARGURA-1]};
    tentativa = desl_rem - {1'b0, b_q};
    hi_d      = '0;
    lo_d      = '0;
    if (op_q == OP_MUL) begin
      hi_d = {1'b0, hi_soma[LARGURA:1]};
      lo_d = {hi_soma[0], lo_q[LARGURA-1:1]};
    end else if (!tentativa[LARGURA]) begin
      hi_d = tentativa;
      lo_d = {lo_q[LARGURA-2:0], 1'b1};
    end else begin
      hi_d = desl_rem;
      lo_d = {lo_q[LARGURA-2:0], 1'b0};
    end
  end

`ifdef ULA_FLAGS_EN
  logic [LARGURA:0] soma_c;
  logic             carry_s, ovf_s, carry_q, ovf_q;

  always_comb begin
    soma_c  = {1'b0, Fonte1} + {1'b0, Fonte2};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    if (op_in == OP_ADD) begin
      carry_s = soma_c[LARGURA];
      ovf_s   = (Fonte1[LARGURA-1] == Fonte2[LARGURA-1]) &&
                (soma_c[LARGURA-1] != Fonte1[LARGURA-1]);
    end else if (op_in == OP_SUB) begin
      carry_s = dif[LARGURA];
      ovf_s   = (Fonte1[LARGURA-1] != Fonte2[LARGURA-1]) &&
                (dif[LARGURA-1] != Fonte1[LARGURA-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (estado_q == OCIOSO && Inicio) begin
      carry_q <= carry_s;
      ovf_q   <= ovf_s;
    end else if (estado_q == CALCULA && cont_q == CONT_UM) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end
  end

  assign Carry    = carry_q;
  assign Overflow = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      op_q        <= OP_ADD;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cont_q      <= '0;
      resultado_q <= '0;
      alto_q      <= '0;
      zero_q      <= 1'b1;
      erro_q      <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (Inicio) begin
            op_q <= op_in;
            b_q  <= Fonte2;
            if (op_in == OP_DIV && Fonte2 == '0) begin
              resultado_q <= '1;
              alto_q      <= Fonte1;
              zero_q      <= 1'b0;
              erro_q      <= 1'b1;
              estado_q    <= FIM;
            end else if (op_in == OP_MUL || op_in == OP_DIV) begin
              hi_q     <= '0;
              lo_q     <= Fonte1;
              cont_q   <= CONT_INI;
              estado_q <= CALCULA;
            end else begin
              resultado_q <= res_simples;
              alto_q      <= '0;
              zero_q      <= (res_simples == '0);
              erro_q      <= 1'b0;
              estado_q    <= FIM;
            end
          end
        end
        CALCULA: begin
          hi_q   <= hi_d;
          lo_q   <= lo_d;
          cont_q <= cont_q - CONT_UM;
          if (cont_q == CONT_UM) begin
            resultado_q <= lo_d;
            alto_q      <= hi_d[LARGURA-1:0];
            zero_q      <= (lo_d == '0);
            erro_q      <= 1'b0;
            estado_q    <= FIM;
          end
        end
        FIM:     estado_q <= OCIOSO;
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign Ocupado       = (estado_q != OCIOSO);
  assign Pronto        = (estado_q == FIM);
  assign Resultado     = resultado_q;
  assign ResultadoAlto = alto_q;
  assign Zero          = zero_q;
  assign ErroDiv       = erro_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: directed cases, handshake timing and random ops
// against an arithmetic reference model.
module tb_ula_multiciclo;
  localparam int unsigned W  = 8;
  localparam int unsigned LC = 4;

  logic         clk = 1'b0;
  logic         rst, Inicio;
  logic [W-1:0] Fonte1, Fonte2;
  logic [2:0]   ULAOp;
  logic         Ocupado, Pronto, Zero, ErroDiv;
  logic [W-1:0] Resultado, ResultadoAlto;
`ifdef ULA_FLAGS_EN
  logic         Carry, Overflow;
`endif

  int n_checks = 0;
  int n_erros  = 0;

  ula_multiciclo #(.LARGURA(W), .LARG_CONT(LC)) dut (
    .clk(clk), .rst(rst), .Inicio(Inicio), .Fonte1(Fonte1), .Fonte2(Fonte2),
    .ULAOp(ULAOp), .Ocupado(Ocupado), .Pronto(Pronto), .Resultado(Resultado),
    .ResultadoAlto(ResultadoAlto), .Zero(Zero),
`ifdef ULA_FLAGS_EN
    .Carry(Carry), .Overflow(Overflow),
`endif
    .ErroDiv(ErroDiv)
  );

  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions
  task automatic modelo(input int unsigned op, input int unsigned a, input int unsigned b,
                        output int unsigned res, output int unsigned alto, output int unsigned erro,
                        output int unsigned lat, output int unsigned cy, output int unsigned ov);
    int unsigned mask = (1 << W) - 1;
    int sa, sb, s;
    int unsigned sh;
    sa = (a >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
    sb = (b >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
    alto = 0; erro = 0; lat = 1; cy = 0; ov = 0; res = 0;
    case (op)
      0: begin res = (a + b) & mask; cy = (a + b > mask); s = sa + sb;
               ov = (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))); end
      1: begin res = (a - b) & mask; cy = (a < b); s = sa - sb;
               ov = (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))); end
      2: res = (a < b) ? 1 : 0;
      3: res = a & b;
      4: res = a | b;
      5: begin sh = b % (1 << LC); res = (sh >= W) ? 0 : (a << sh) & mask; end
      6: begin res = (a * b) & mask; alto = (a * b) >> W; lat = W + 1; end
      default: begin
        if (b == 0) begin res = mask; alto = a; erro = 1; end
        else begin res = a / b; alto = a % b; lat = W + 1; end
      end
    endcase
  endtask

  task automatic executa(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit ruido);
    int unsigned res, alto, erro, lat, cy, ov;
    int lat_obs;
    bit ocup_ok;
    string t;
    modelo(op, a, b, res, alto, erro, lat, cy, ov);
    t = $sformatf("op%0d %0h,%0h", op, a, b);
    @(negedge clk);
    ULAOp = op; Fonte1 = a; Fonte2 = b; Inicio = 1'b1;
    @(posedge clk); #1;
    Inicio = 1'b0; Fonte1 = W'($urandom); Fonte2 = W'($urandom); ULAOp = 3'($urandom);
    lat_obs = 0; ocup_ok = 1'b1;
    for (int c = 1; c <= 40 && lat_obs == 0; c++) begin
      @(negedge clk);
      if (!Ocupado) ocup_ok = 1'b0;
      if (Pronto) begin lat_obs = c; Inicio = 1'b0; end
      else if (ruido) Inicio = 1'($urandom_range(0, 1));
    end
    verifica({t, " latency"}, lat_obs, lat);
    verifica({t, " busy"}, 32'(ocup_ok), 1);
    verifica({t, " res"}, Resultado, res);
    verifica({t, " hi"}, ResultadoAlto, alto);
    verifica({t, " zero"}, Zero, (res == 0) ? 1 : 0);
    verifica({t, " errdiv"}, ErroDiv, erro);
`ifdef ULA_FLAGS_EN
    verifica({t, " carry"}, Carry, cy);
    verifica({t, " ovf"}, Overflow, ov);
`endif
    @(negedge clk);
    verifica({t, " pulse"}, {Pronto, Ocupado}, 2'b00);
  endtask

  initial begin
    int pr;
    rst = 1'b1; Inicio = 1'b0; Fonte1 = '0; Fonte2 = '0; ULAOp = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    verifica("rst busy", Ocupado, 0);
    verifica("rst pronto", Pronto, 0);
    verifica("rst res", {Resultado, ResultadoAlto}, 0);
    verifica("rst zero", Zero, 1);
    verifica("rst errdiv", ErroDiv, 0);

    executa(3'b000, 8'd2, 8'd4, 0);
    executa(3'b001, 8'd2, 8'd4, 0);
    executa(3'b001, 8'd6, 8'd6, 0);
    executa(3'b010, 8'd3, 8'd5, 0);
    executa(3'b010, 8'd5, 8'd3, 0);
    executa(3'b110, 8'd200, 8'd3, 1);
    executa(3'b111, 8'd100, 8'd7, 1);
    executa(3'b111, 8'd55, 8'd0, 0);
    executa(3'b111, 8'd255, 8'd1, 0);
    executa(3'b110, 8'd255, 8'd255, 0);
    executa(3'b101, 8'h81, 8'd1, 0);
    executa(3'b101, 8'h81, 8'd8, 0);
    executa(3'b101, 8'h81, 8'h17, 0);
    executa(3'b011, 8'hF0, 8'h3C, 0);
    executa(3'b100, 8'hF0, 8'h3C, 0);
    executa(3'b000, 8'd200, 8'd100, 0);
    executa(3'b000, 8'd100, 8'd100, 0);
    executa(3'b001, 8'd3, 8'd5, 0);
    executa(3'b001, 8'h80, 8'd1, 0);

    // Inicio held high: accepts every other cycle
    @(negedge clk);
    ULAOp = 3'b000; Fonte1 = 8'd1; Fonte2 = 8'd1; Inicio = 1'b1;
    pr = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      pr = (pr << 1) | int'(Pronto);
    end
    Inicio = 1'b0;
    verifica("b2b pronto", pr, 6'b101010);
    verifica("b2b res", Resultado, 2);

    // Reset in the 4th CALCULA cycle of a MUL
    @(negedge clk);
    ULAOp = 3'b110; Fonte1 = 8'd200; Fonte2 = 8'd3; Inicio = 1'b1;
    @(negedge clk);
    Inicio = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    verifica("abort busy", Ocupado, 0);
    verifica("abort res", Resultado, 0);
    verifica("abort zero", Zero, 1);
    pr = 0;
    for (int k = 0; k < 12; k++) begin
      if (Pronto) pr++;
      @(negedge clk);
    end
    verifica("abort nopronto", pr, 0);

    for (int i = 0; i < 150; i++)
      executa(3'($urandom), W'($urandom), W'((i % 10 == 0) ? 0 : $urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_erros);
    $finish;
  end

endmodule
